pc_bitmap_builder: RTL

Upstream feeder of the continuous monitoring system's positive-bit counter. It hashes each committed program counter into a DATA_WIDTH-bit "touched" bitmap over a monitoring window. At window close it snapshots the bitmap onto a stable output vector, so the downstream popcount reports the distinct-hash-bucket count (code-footprint estimate) for that window. It also flags first-touch events per cycle.

---
 rtl/pc_bitmap_builder_pkg.sv | 8 +
 rtl/pc_bitmap_builder_if.sv | 24 ++
 rtl/pc_bitmap_builder_hash.sv | 10 +
 rtl/pc_bitmap_builder.sv | 66 ++++++
 4 files changed

// File: rtl/pc_bitmap_builder_pkg.sv
// pc_bitmap_builder_pkg: shared widths and FSM state type for the PC bitmap path
package pc_bitmap_builder_pkg;
    localparam int PC_WIDTH = 64;
    localparam int DATA_WIDTH = 1024;
    localparam int DATA_WIDTH_LOG2 = 10;
    localparam int WINDOW_CNT_WIDTH = 32;
    typedef enum logic {IDLE, COLLECT} state_e;
endpackage

// File: rtl/pc_bitmap_builder_if.sv
// pc_bitmap_builder_if: PC feed, window control and snapshot outputs
interface pc_bitmap_builder_if #(
    parameter int DATA_WIDTH = 1024,
    parameter int PC_WIDTH = 64,
    parameter int WINDOW_CNT_WIDTH = 32
);
    logic enable;
    logic pc_valid;
    logic [PC_WIDTH-1:0] pc_in;
    logic [WINDOW_CNT_WIDTH-1:0] window_len;
    logic window_close;
    logic [DATA_WIDTH-1:0] bitmap_out;
    logic snapshot_valid;
    logic first_touch;
    logic [15:0] windows_closed;
    modport master (
        output enable, pc_valid, pc_in, window_len, window_close,
        input bitmap_out, snapshot_valid, first_touch, windows_closed
    );
    modport slave (
        input enable, pc_valid, pc_in, window_len, window_close,
        output bitmap_out, snapshot_valid, first_touch, windows_closed
    );
endinterface

// File: rtl/pc_bitmap_builder_hash.sv
// pc_bitmap_hash: folds two PC slices above the byte offset into a bitmap index
module pc_bitmap_hash #(
    parameter int DATA_WIDTH_LOG2 = 10,
    parameter int PC_WIDTH = 64
) (
    input  logic [PC_WIDTH-1:0]        pc_i,
    output logic [DATA_WIDTH_LOG2-1:0] idx_o
);
    assign idx_o = pc_i[DATA_WIDTH_LOG2+1:2] ^ pc_i[2*DATA_WIDTH_LOG2+1:DATA_WIDTH_LOG2+2];
endmodule

// File: rtl/pc_bitmap_builder.sv
// pc_bitmap_builder: accumulates hashed PCs per window and snapshots the bitmap at close
module pc_bitmap_builder
    import pc_bitmap_builder_pkg::*;
#(
    parameter int DATA_WIDTH = pc_bitmap_builder_pkg::DATA_WIDTH,
    parameter int DATA_WIDTH_LOG2 = pc_bitmap_builder_pkg::DATA_WIDTH_LOG2,
    parameter int PC_WIDTH = pc_bitmap_builder_pkg::PC_WIDTH,
    parameter int WINDOW_CNT_WIDTH = pc_bitmap_builder_pkg::WINDOW_CNT_WIDTH
) (
    input logic clk,
    input logic rst,
    pc_bitmap_builder_if.slave b
);
    state_e state_q;
    logic [DATA_WIDTH-1:0] live_q, bitmap_q;
    logic [WINDOW_CNT_WIDTH-1:0] cnt_q;
    logic [15:0] closed_q;
    logic snap_q, touch_q;
    logic [DATA_WIDTH_LOG2-1:0] idx;
    logic collect, auto_close, close;
    logic [DATA_WIDTH-1:0] hit_d;

    pc_bitmap_hash #(.DATA_WIDTH_LOG2(DATA_WIDTH_LOG2), .PC_WIDTH(PC_WIDTH)) u_hash (
        .pc_i (b.pc_in),
        .idx_o(idx)
    );

    assign collect = (state_q == COLLECT) && b.enable;
    assign auto_close = collect && (b.window_len != '0) && (cnt_q == b.window_len - 1'b1);
    assign close = b.window_close || auto_close;
    // The closing cycle's PC belongs to the window being closed.
    assign hit_d = (collect && b.pc_valid) ? (DATA_WIDTH'(1) << idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            live_q <= '0;
            bitmap_q <= '0;
            cnt_q <= '0;
            closed_q <= '0;
            snap_q <= 1'b0;
            touch_q <= 1'b0;
        end else begin
            if (close) begin
                bitmap_q <= live_q | hit_d;
                live_q <= '0;
                cnt_q <= '0;
                closed_q <= closed_q + 16'd1;
            end else if (collect) begin
                live_q <= live_q | hit_d;
                cnt_q <= cnt_q + 1'b1;
            end
            snap_q <= close;
            touch_q <= collect && b.pc_valid && !live_q[idx];
            if (state_q == IDLE && b.enable) begin
                state_q <= COLLECT;
                cnt_q <= '0;
            end
        end
    end

    assign b.bitmap_out = bitmap_q;
    assign b.snapshot_valid = snap_q;
    assign b.first_touch = touch_q;
    assign b.windows_closed = closed_q;
endmodule
